// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer: steers the external PC register, runs the memory read handshake
// and hands fetched words to decode, with branch redirect, flush and halt handling.
module pc_fetch_sequencer #(
    parameter int                ADDR_W       = 16,
    parameter int                DATA_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              halt,
    input  logic [ADDR_W-1:0] pc_value,
    output logic              pc_write_en,
    output logic              pc_inc,
    output logic [ADDR_W-1:0] pc_data,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_ack,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir_data,
    input  logic              ir_ready,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              busy
);

    typedef enum logic [2:0] {INIT, IDLE, FETCH, ISSUE, DRAIN, BRANCH} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] target;
    logic              first_cycle;
    logic              load_ir, load_target;

    // first_cycle marks the entry cycle of ISSUE so the PC steps exactly once per word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= INIT;
            ir_data     <= '0;
            target      <= '0;
            first_cycle <= 1'b1;
        end else begin
            state       <= state_nxt;
            first_cycle <= (state != ISSUE);
            if (load_ir)     ir_data <= mem_rd_data;
            if (load_target) target  <= br_target;
        end
    end

    always_comb begin
        state_nxt   = state;
        load_ir     = 1'b0;
        load_target = 1'b0;
        pc_write_en = 1'b0;
        pc_inc      = 1'b0;
        pc_data     = '0;
        mem_rd_req  = 1'b0;
        mem_addr    = '0;
        ir_valid    = 1'b0;
        case (state)
            INIT: begin
                pc_write_en = 1'b1;
                pc_data     = RESET_VECTOR;
                state_nxt   = IDLE;
            end
            IDLE: begin
                if (br_valid) begin
                    load_target = 1'b1;
                    state_nxt   = BRANCH;
                end else if (start && !halt) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                mem_rd_req = 1'b1;
                mem_addr   = pc_value;
                // a redirect without the ack still owes us one response: drain it first
                if (br_valid) begin
                    load_target = 1'b1;
                    state_nxt   = mem_rd_ack ? BRANCH : DRAIN;
                end else if (mem_rd_ack) begin
                    load_ir   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            DRAIN: begin
                if (br_valid)   load_target = 1'b1;
                if (mem_rd_ack) state_nxt   = BRANCH;
            end
            ISSUE: begin
                pc_inc   = first_cycle;
                ir_valid = !br_valid;
                if (br_valid) begin
                    load_target = 1'b1;
                    state_nxt   = BRANCH;
                end else if (ir_ready) begin
                    state_nxt = halt ? IDLE : FETCH;
                end
            end
            BRANCH: begin
                pc_write_en = 1'b1;
                pc_data     = target;
                state_nxt   = halt ? IDLE : FETCH;
            end
            default: state_nxt = INIT;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
